// File: rtl/qar_exec_checker_if.sv
// qar_exec_checker_if: table config, snooped store bus and verdict outputs of the execution checker
interface qar_exec_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_CHECKS = 4
);
    localparam int IW = NUM_CHECKS > 1 ? $clog2(NUM_CHECKS) : 1;
    logic start;
    logic cfg_we;
    logic [IW-1:0] cfg_idx;
    logic cfg_en;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic mem_we;
    logic busy;
    logic done;
    logic pass;
    logic [1:0] fail_code;
    logic [IW-1:0] fail_idx;
    logic [15:0] write_count;
    logic [31:0] cycle_count;
    modport master (
        output start, cfg_we, cfg_idx, cfg_en, cfg_addr, cfg_data, mem_addr, mem_wdata, mem_we,
        input busy, done, pass, fail_code, fail_idx, write_count, cycle_count
    );
    modport slave (
        input start, cfg_we, cfg_idx, cfg_en, cfg_addr, cfg_data, mem_addr, mem_wdata, mem_we,
        output busy, done, pass, fail_code, fail_idx, write_count, cycle_count
    );
endinterface

// File: rtl/qar_exec_checker.sv
// qar_exec_checker: checks snooped core stores against a programmable expected-store table
module qar_exec_checker #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_CHECKS = 4,
    parameter int TIMEOUT = 1024,
    parameter bit IN_ORDER = 1'b0
) (
    input logic clk,
    input logic rst_n,
    qar_exec_checker_if.slave bus
);
    localparam int IW = NUM_CHECKS > 1 ? $clog2(NUM_CHECKS) : 1;
    localparam int PW = $clog2(NUM_CHECKS + 1);
    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
    state_t state, state_nx;
    logic [NUM_CHECKS-1:0] en, seen, en_w, seen_nx;
    logic [ADDR_W-1:0] addr [NUM_CHECKS];
    logic [DATA_W-1:0] data [NUM_CHECKS];
    logic [PW-1:0] ptr;
    logic cfg_ok, hit, mism, ordv, complete;
    int hit_idx, nxt, first;
    assign cfg_ok = bus.cfg_we && state != RUN && int'(bus.cfg_idx) < NUM_CHECKS;
    // en_w lets a run started alongside a config write see the new entry when picking its first index
    always_comb begin
        hit = 1'b0;
        hit_idx = 0;
        nxt = NUM_CHECKS;
        first = NUM_CHECKS;
        en_w = en;
        if (cfg_ok) en_w[bus.cfg_idx] = bus.cfg_en;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (bus.mem_we && en[i] && !seen[i] && addr[i] == bus.mem_addr) begin
                hit = 1'b1;
                hit_idx = i;
            end
            if (en_w[i]) first = i;
        end
        for (int i = NUM_CHECKS - 1; i >= 0; i--)
            if (en[i] && i > hit_idx) nxt = i;
        seen_nx = seen;
        if (hit) seen_nx[hit_idx] = 1'b1;
        mism = hit && bus.mem_wdata != data[hit_idx];
        ordv = IN_ORDER && hit && hit_idx != int'(ptr);
        complete = (seen_nx & en) == en;
        state_nx = state;
        if (state != RUN) state_nx = bus.start ? RUN : state;
        else if (mism || ordv) state_nx = FAIL;
        else if (complete) state_nx = PASS;
        else if (bus.cycle_count == TIMEOUT_M1) state_nx = FAIL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            en <= '0;
            seen <= '0;
            ptr <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                addr[i] <= '0;
                data[i] <= '0;
            end
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.pass <= 1'b0;
            bus.fail_code <= 2'd0;
            bus.fail_idx <= '0;
            bus.write_count <= '0;
            bus.cycle_count <= '0;
        end else begin
            state <= state_nx;
            bus.busy <= state_nx == RUN;
            bus.done <= state_nx == PASS || state_nx == FAIL;
            bus.pass <= state_nx == PASS;
            if (cfg_ok) begin
                en[bus.cfg_idx] <= bus.cfg_en;
                addr[bus.cfg_idx] <= bus.cfg_addr;
                data[bus.cfg_idx] <= bus.cfg_data;
            end
            if (state != RUN && bus.start) begin
                seen <= '0;
                ptr <= PW'(first);
                bus.fail_code <= 2'd0;
                bus.fail_idx <= '0;
                bus.write_count <= '0;
                bus.cycle_count <= '0;
            end else if (state == RUN) begin
                bus.cycle_count <= bus.cycle_count + 32'd1;
                if (bus.mem_we && bus.write_count != 16'hFFFF) bus.write_count <= bus.write_count + 16'd1;
                if (mism || ordv) begin
                    bus.fail_code <= mism ? 2'd1 : 2'd2;
                    bus.fail_idx <= IW'(hit_idx);
                end else begin
                    seen <= seen_nx;
                    if (hit) ptr <= PW'(nxt);
                    if (!complete && bus.cycle_count == TIMEOUT_M1) bus.fail_code <= 2'd3;
                end
            end
        end
    end
endmodule

// File: tb/tb_qar_exec_checker.sv
// tb_qar_exec_checker: scoreboard bench driving an unordered and an in-order checker with identical traffic
module tb_qar_exec_checker;
    localparam int NC = 3;
    localparam int TO = 16;
    typedef struct {
        logic pass;
        logic [1:0] code;
        logic [1:0] idx;
        logic [15:0] wc;
        logic [31:0] cc;
    } res_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start, cfg_we, cfg_en, mem_we;
    logic [1:0] cfg_idx;
    logic [31:0] cfg_addr, cfg_data, mem_addr, mem_wdata;
    logic [NC-1:0] tbl_en;
    logic [31:0] tbl_a [NC];
    logic [31:0] tbl_d [NC];
    logic st_we [TO];
    logic [31:0] st_a [TO];
    logic [31:0] st_d [TO];
    logic [31:0] pool [4] = '{32'd64, 32'd68, 32'd72, 32'h100};
    res_t q0[$];
    res_t q1[$];
    int total = 0;
    int bad = 0;
    logic p0 = 1'b0;
    logic p1 = 1'b0;
    always #5 clk = ~clk;
    qar_exec_checker_if #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(NC)) b0 ();
    qar_exec_checker_if #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(NC)) b1 ();
    qar_exec_checker #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(NC), .TIMEOUT(TO), .IN_ORDER(1'b0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    qar_exec_checker #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(NC), .TIMEOUT(TO), .IN_ORDER(1'b1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    assign b0.start = start;
    assign b0.cfg_we = cfg_we;
    assign b0.cfg_idx = cfg_idx;
    assign b0.cfg_en = cfg_en;
    assign b0.cfg_addr = cfg_addr;
    assign b0.cfg_data = cfg_data;
    assign b0.mem_addr = mem_addr;
    assign b0.mem_wdata = mem_wdata;
    assign b0.mem_we = mem_we;
    assign b1.start = start;
    assign b1.cfg_we = cfg_we;
    assign b1.cfg_idx = cfg_idx;
    assign b1.cfg_en = cfg_en;
    assign b1.cfg_addr = cfg_addr;
    assign b1.cfg_data = cfg_data;
    assign b1.mem_addr = mem_addr;
    assign b1.mem_wdata = mem_wdata;
    assign b1.mem_we = mem_we;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: walk RUN cycles; in-order means the hit must be the lowest enabled entry not yet seen
    function automatic res_t model(input bit ord);
        res_t r;
        bit seen [NC];
        bit all;
        int m;
        r = '{default: 0};
        for (int i = 0; i < NC; i++) seen[i] = 1'b0;
        for (int k = 0; k < TO; k++) begin
            m = -1;
            r.cc = 32'(k + 1);
            if (st_we[k]) begin
                if (r.wc != 16'hFFFF) r.wc = r.wc + 16'd1;
                for (int i = NC - 1; i >= 0; i--)
                    if (tbl_en[i] && !seen[i] && tbl_a[i] == st_a[k]) m = i;
            end
            if (m >= 0) begin
                if (tbl_d[m] != st_d[k]) begin
                    r.code = 2'd1;
                    r.idx = 2'(m);
                    return r;
                end
                if (ord)
                    for (int i = 0; i < m; i++)
                        if (tbl_en[i] && !seen[i]) begin
                            r.code = 2'd2;
                            r.idx = 2'(m);
                            return r;
                        end
                seen[m] = 1'b1;
            end
            all = 1'b1;
            for (int i = 0; i < NC; i++) if (tbl_en[i] && !seen[i]) all = 1'b0;
            if (all) begin
                r.pass = 1'b1;
                return r;
            end
            if (k == TO - 1) r.code = 2'd3;
        end
        return r;
    endfunction

    task automatic mon_check(input string nm, input bit w, input logic ps, input logic [1:0] fc,
                             input logic [1:0] fi, input logic [15:0] wc, input logic [31:0] cc);
        res_t e;
        if ((w ? q1.size() : q0.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL %s: verdict with no expected entry", nm);
            return;
        end
        if (w) e = q1.pop_front();
        else e = q0.pop_front();
        chk({nm, " pass"}, 64'(ps), 64'(e.pass));
        chk({nm, " fail_code"}, 64'(fc), 64'(e.code));
        chk({nm, " fail_idx"}, 64'(fi), 64'(e.idx));
        chk({nm, " write_count"}, 64'(wc), 64'(e.wc));
        chk({nm, " cycle_count"}, 64'(cc), 64'(e.cc));
    endtask

    always @(negedge clk) begin
        if (b0.done && !p0) mon_check("unordered", 1'b0, b0.pass, b0.fail_code, b0.fail_idx, b0.write_count, b0.cycle_count);
        if (b1.done && !p1) mon_check("in_order", 1'b1, b1.pass, b1.fail_code, b1.fail_idx, b1.write_count, b1.cycle_count);
        p0 = b0.done;
        p1 = b1.done;
    end

    task automatic clear_stim();
        tbl_en = '0;
        for (int i = 0; i < NC; i++) begin
            tbl_a[i] = 32'h0;
            tbl_d[i] = 32'h0;
        end
        for (int k = 0; k < TO; k++) begin
            st_we[k] = 1'b0;
            st_a[k] = 32'h0;
            st_d[k] = 32'h0;
        end
    endtask

    task automatic set_entry(input int i, input logic [31:0] a, input logic [31:0] d);
        tbl_en[i] = 1'b1;
        tbl_a[i] = a;
        tbl_d[i] = d;
    endtask

    task automatic set_store(input int k, input logic [31:0] a, input logic [31:0] d);
        st_we[k] = 1'b1;
        st_a[k] = a;
        st_d[k] = d;
    endtask

    // Out-of-range decoy write, then the table (last entry written together with start), then TO store cycles
    task automatic do_run(input bit cfg);
        res_t r0, r1;
        r0 = model(1'b0);
        r1 = model(1'b1);
        q0.push_back(r0);
        q1.push_back(r1);
        if (cfg) begin
            @(negedge clk);
            cfg_we = 1'b1;
            cfg_idx = 2'd3;
            cfg_en = 1'b1;
            cfg_addr = 32'h200;
            cfg_data = 32'h0;
            for (int i = 0; i < NC; i++) begin
                @(negedge clk);
                cfg_idx = 2'(i);
                cfg_en = tbl_en[i];
                cfg_addr = tbl_a[i];
                cfg_data = tbl_d[i];
                start = (i == NC - 1);
            end
        end else begin
            @(negedge clk);
            cfg_we = 1'b0;
            start = 1'b1;
        end
        for (int k = 0; k <= TO; k++) begin
            @(negedge clk);
            chk("unordered busy/done", 64'({b0.busy, b0.done}), 64'({k < int'(r0.cc), k >= int'(r0.cc)}));
            chk("in_order busy/done", 64'({b1.busy, b1.done}), 64'({k < int'(r1.cc), k >= int'(r1.cc)}));
            start = 1'b0;
            cfg_we = (k < TO) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_idx = 2'($urandom_range(0, NC - 1));
            cfg_en = 1'b1;
            cfg_addr = $urandom;
            cfg_data = $urandom;
            mem_we = (k < TO) ? st_we[k] : 1'b0;
            mem_addr = (k < TO) ? st_a[k] : 32'h0;
            mem_wdata = (k < TO) ? st_d[k] : 32'h0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int j;
        start = 1'b0;
        cfg_we = 1'b0;
        cfg_idx = 2'd0;
        cfg_en = 1'b0;
        cfg_addr = 32'h0;
        cfg_data = 32'h0;
        mem_we = 1'b0;
        mem_addr = 32'h0;
        mem_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset outputs unordered", 64'({b0.busy, b0.done, b0.pass, b0.fail_code, b0.fail_idx, b0.write_count, b0.cycle_count}), 64'h0);
        chk("reset outputs in_order", 64'({b1.busy, b1.done, b1.pass, b1.fail_code, b1.fail_idx, b1.write_count, b1.cycle_count}), 64'h0);
        rst_n = 1'b1;
        // two-entry table, stores out of index order
        clear_stim();
        set_entry(0, 32'd64, 32'd14);
        set_entry(1, 32'd68, 32'h123);
        set_store(0, 32'd68, 32'h123);
        set_store(1, 32'd64, 32'd14);
        do_run(1'b1);
        // data mismatch
        clear_stim();
        set_entry(0, 32'd64, 32'd14);
        set_entry(1, 32'd68, 32'h123);
        set_store(0, 32'd64, 32'd13);
        do_run(1'b1);
        // stores in index order
        clear_stim();
        set_entry(0, 32'd64, 32'd14);
        set_entry(1, 32'd68, 32'h123);
        set_store(2, 32'd64, 32'd14);
        set_store(5, 32'd68, 32'h123);
        do_run(1'b1);
        // timeout with no stores
        clear_stim();
        set_entry(0, 32'd64, 32'd5);
        do_run(1'b1);
        // matching store on the last allowed RUN cycle
        clear_stim();
        set_entry(0, 32'd64, 32'd5);
        set_store(TO - 1, 32'd64, 32'd5);
        do_run(1'b1);
        // duplicate table addresses check successive stores
        clear_stim();
        set_entry(0, 32'd64, 32'd0);
        set_entry(1, 32'd64, 32'd14);
        set_store(0, 32'h100, 32'd7);
        set_store(1, 32'd64, 32'd0);
        set_store(2, 32'd64, 32'd14);
        do_run(1'b1);
        // asynchronous reset mid-run wipes the table
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_idx = 2'd0;
        cfg_en = 1'b1;
        cfg_addr = 32'd64;
        cfg_data = 32'd5;
        start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset unordered", 64'({b0.busy, b0.done, b0.pass, b0.fail_code, b0.fail_idx, b0.write_count, b0.cycle_count}), 64'h0);
        chk("async reset in_order", 64'({b1.busy, b1.done, b1.pass, b1.fail_code, b1.fail_idx, b1.write_count, b1.cycle_count}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_stim();
        do_run(1'b0);
        // randomized runs
        for (int n = 0; n < 80; n++) begin
            clear_stim();
            for (int i = 0; i < NC; i++) begin
                tbl_en[i] = $urandom_range(0, 3) != 0;
                tbl_a[i] = pool[$urandom_range(0, 3)];
                tbl_d[i] = 32'($urandom_range(0, 3));
            end
            for (int k = 0; k < TO; k++) begin
                j = $urandom_range(0, NC - 1);
                st_we[k] = $urandom_range(0, 4) < 3;
                if ($urandom_range(0, 3) != 0) begin
                    st_a[k] = tbl_a[j];
                    st_d[k] = tbl_d[j];
                end else begin
                    st_a[k] = pool[$urandom_range(0, 3)];
                    st_d[k] = 32'($urandom_range(0, 3));
                end
            end
            do_run(1'b1);
        end
        @(negedge clk);
        chk("unordered verdicts outstanding", 64'(q0.size()), 64'h0);
        chk("in_order verdicts outstanding", 64'(q1.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qar_exec_checker.md
# qar_exec_checker

Parametrised execution checker for QAR-Core simulation and FPGA bring-up. It snoops the core's data-memory write bus (`mem_addr`/`mem_wdata`/`mem_we`) against a programmable table of expected stores, with optional ordering and a watchdog. It reports a registered pass/fail verdict with a failure code and index. It sits beside `qar_core`, is driven by the bench or a debug register block, and replaces hard-coded end-of-run memory peeks with in-flight checking.

## Interface
Parameters:
- ADDR_W, 32, width of snooped and expected addresses
- DATA_W, 32, width of snooped and expected data
- NUM_CHECKS, 4, number of expected-store table entries (≥1)
- TIMEOUT, 1024, maximum RUN cycles before a timeout failure (≥2)
- IN_ORDER, 0, when 1, matched stores must hit table entries in ascending index order

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a check run
- cfg_we  in  1  write one table entry
- cfg_idx  in  IW=max(1,$clog2(NUM_CHECKS))  entry index
- cfg_en  in  1  entry enable written with the entry
- cfg_addr  in  ADDR_W  expected store address
- cfg_data  in  DATA_W  expected store data
- mem_addr  in  ADDR_W  snooped core address
- mem_wdata  in  DATA_W  snooped core write data
- mem_we  in  1  snooped core write strobe
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- fail_code  out  2  0 none, 1 data mismatch, 2 order violation, 3 timeout
- fail_idx  out  IW  entry that caused a code 1 or 2 failure, else 0
- write_count  out  16  stores seen during the run, saturating at 0xFFFF
- cycle_count  out  32  cycles spent in RUN

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset enters IDLE, clears every table entry (en, addr, data, seen) and drives all outputs to 0.
- Table config: `cfg_we` is accepted in IDLE/PASS/FAIL and ignored in RUN. An out-of-range `cfg_idx` is ignored.
- `start` in IDLE/PASS/FAIL: clears the seen bits, write_count, cycle_count, fail_code, fail_idx and the order pointer, then enters RUN. `start` in RUN is ignored. `cfg_we` and `start` in the same cycle: the config write takes effect first, so the new entry is used by the run.
- RUN, per cycle with `mem_we`=1:
  - Increment write_count (saturating).
  - Match target: the lowest-index entry with en=1, seen=0 and addr==mem_addr. Duplicate table addresses therefore check successive stores to one location.
  - No match: the store is ignored apart from the count. This covers stack traffic and repeats to already-seen addresses.
  - Match with mem_wdata≠data: enter FAIL, code 1, fail_idx=index.
  - IN_ORDER=1 and index≠order pointer: enter FAIL, code 2, fail_idx=index. Mismatch takes priority over order.
  - Otherwise set seen; when IN_ORDER=1, advance the pointer to the next enabled index.
- Completion: all enabled entries seen, including any set this cycle, moves RUN to PASS. With zero enabled entries, PASS follows the first RUN cycle.
- Timeout: cycle_count increments every RUN cycle starting from 0. When cycle_count==TIMEOUT-1 and the run neither completes nor fails that cycle, enter FAIL with code 3. Completion or a data failure in the same cycle wins over timeout.
- PASS/FAIL hold until `start` or reset. Counters freeze at their final values.

## Timing
- All outputs are registered. No combinational path from the snoop bus to the outputs.
- `start` sampled at edge N: busy=1 after N, and stores are sampled from edge N+1.
- A deciding store sampled at edge M: done/pass/fail_code are valid after M, and busy falls at M.
- An `rst_n` assertion mid-run takes effect immediately (asynchronous). The table is lost and the checker must be reprogrammed.
- cycle_count reads exactly TIMEOUT at a timeout failure (the final increment happens on the failing edge).

## Test plan
- Table {0:64→14, 1:68→0x123}, IN_ORDER=0; stores 68=0x123 then 64=14 → pass=1, fail_code=0, write_count=2.
- Same table; store 64=13 → done=1, pass=0, fail_code=1, fail_idx=0, on the edge after the store.
- IN_ORDER=1, same table; store 68=0x123 first → fail_code=2, fail_idx=1. With the order reversed, the run passes.
- TIMEOUT=16, one entry, no stores → fail_code=3, cycle_count=16, busy low 16 cycles after start. The matching store on the 16th RUN cycle gives pass instead.
- Table {0:64→0, 1:64→14}, stores 0x100=7, 64=0, 64=14 → pass=1, write_count=3. The store 64=14 checks entry 1, not the already-seen entry 0.
- rst_n pulsed low mid-RUN → all outputs 0 and entries cleared; a following `start` with no config → pass after one RUN cycle.
